// File: rtl/lzc_norm_pipe.sv
// rtl/lzc_norm_pipe.sv - two-stage leading/trailing zero counter and normaliser with tag sideband
module lzc_norm_pipe #(
  parameter int WIDTH = 49,
  parameter int CNT_W = $clog2(WIDTH + 1),
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NG   = (WIDTH + 7) / 8;
  localparam int PADW = NG * 8;
  localparam int PAD  = PADW - WIDTH;

  logic [PADW-1:0]     w_ext;
  logic [NG-1:0]       w_nz;
  logic [NG-1:0][2:0]  w_lcnt;
  logic                w_ld1;
  logic                w_ld2;
  logic [CNT_W-1:0]    w_cnt;
  logic                w_zero;
  logic [WIDTH-1:0]    w_norm;

  logic                r1_valid;
  logic [WIDTH-1:0]    r1_data;
  logic                r1_mode;
  logic [TAG_W-1:0]    r1_tag;
  logic [NG-1:0]       r1_nz;
  logic [NG-1:0][2:0]  r1_lcnt;

  logic                r2_valid;
  logic [CNT_W-1:0]    r2_cnt;
  logic                r2_zero;
  logic [WIDTH-1:0]    r2_norm;
  logic [TAG_W-1:0]    r2_tag;

  // Per-group local count: the last set bit visited wins, so the scan order picks MSB or LSB side.
  always_comb begin
    w_ext = '0;
    w_ext[WIDTH-1:0] = in_data;
    w_nz = '0;
    w_lcnt = '0;
    for (int g = 0; g < NG; g++) begin
      w_nz[g] = |w_ext[g*8 +: 8];
      for (int b = 0; b < 8; b++) begin
        if (in_mode) begin
          if (w_ext[g*8 + 7 - b]) w_lcnt[g] = 3'(7 - b);
        end else begin
          if (w_ext[g*8 + b]) w_lcnt[g] = 3'(7 - b);
        end
      end
    end
  end

  // Leading counts are taken over the zero-padded operand, so the pad bits are removed afterwards.
  always_comb begin
    w_cnt = CNT_W'(WIDTH);
    if (r1_mode) begin
      for (int g = NG - 1; g >= 0; g--) begin
        if (r1_nz[g]) w_cnt = CNT_W'(g * 8 + int'(r1_lcnt[g]));
      end
    end else begin
      for (int g = 0; g < NG; g++) begin
        if (r1_nz[g]) w_cnt = CNT_W'((NG - 1 - g) * 8 + int'(r1_lcnt[g]) - PAD);
      end
    end
    w_zero = ~|r1_nz;
    w_norm = r1_mode ? (r1_data >> w_cnt) : (r1_data << w_cnt);
  end

  assign w_ld2    = r1_valid && (!r2_valid || out_ready);
  assign in_ready = !rst && (!r1_valid || !r2_valid || out_ready);
  assign w_ld1    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_data  <= '0;
      r1_mode  <= 1'b0;
      r1_tag   <= '0;
      r1_nz    <= '0;
      r1_lcnt  <= '0;
      r2_valid <= 1'b0;
      r2_cnt   <= '0;
      r2_zero  <= 1'b0;
      r2_norm  <= '0;
      r2_tag   <= '0;
    end else begin
      if (w_ld1) begin
        r1_valid <= 1'b1;
        r1_data  <= in_data;
        r1_mode  <= in_mode;
        r1_tag   <= in_tag;
        r1_nz    <= w_nz;
        r1_lcnt  <= w_lcnt;
      end else if (w_ld2) begin
        r1_valid <= 1'b0;
      end
      if (w_ld2) begin
        r2_valid <= 1'b1;
        r2_cnt   <= w_cnt;
        r2_zero  <= w_zero;
        r2_norm  <= w_norm;
        r2_tag   <= r1_tag;
      end else if (out_ready) begin
        r2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r2_valid;
  assign out_cnt   = r2_cnt;
  assign out_zero  = r2_zero;
  assign out_norm  = r2_norm;
  assign out_tag   = r2_tag;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb/tb_lzc_norm_pipe.sv - scoreboard bench: directed cases at WIDTH=49, randomized at 49/24/106
module tb_lzc_norm_pipe;

  localparam int DW     = 49;
  localparam int DCW    = $clog2(DW + 1);
  localparam int N_RAND = 3400;

  typedef struct {
    logic [127:0] norm;
    int           cnt;
    bit           z;
    logic [7:0]   tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit start_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: walk bit by bit from the relevant end of the operand.
  function automatic void ref_model(input logic [127:0] d, input bit m, input int w,
                                    output int cnt, output bit z, output logic [127:0] nrm);
    logic [127:0] mask;
    mask = (w == 128) ? '1 : ((128'(1) << w) - 128'(1));
    d = d & mask;
    cnt = 0;
    if (d == '0) begin
      cnt = w;
      z = 1'b1;
      nrm = '0;
    end else begin
      z = 1'b0;
      if (!m) begin
        while (d[w-1-cnt] == 1'b0) cnt++;
        nrm = (d << cnt) & mask;
      end else begin
        while (d[cnt] == 1'b0) cnt++;
        nrm = d >> cnt;
      end
    end
  endfunction

  function automatic logic [127:0] rnd_op(input int w);
    logic [127:0] r;
    int sh;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    sh = $urandom_range(0, w - 1);
    case ($urandom_range(0, 7))
      0:       r = '0;
      1, 2, 3: r = r >> (128 - w + sh);
      4, 5, 6: r = r << sh;
      default: r = 128'(1) << sh;
    endcase
    return r;
  endfunction

  logic           d_in_valid, d_in_ready, d_in_mode, d_out_valid, d_out_ready, d_out_zero;
  logic [DW-1:0]  d_in_data, d_out_norm;
  logic [7:0]     d_in_tag, d_out_tag;
  logic [DCW-1:0] d_out_cnt;
  exp_t dq[$];
  int d_recv = 0;
  int d_out_prev = 0;
  int d_out_last = 0;

  lzc_norm_pipe #(.WIDTH(DW), .TAG_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .in_mode(d_in_mode), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_cnt(d_out_cnt),
    .out_zero(d_out_zero), .out_norm(d_out_norm), .out_tag(d_out_tag)
  );

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (d_out_valid && d_out_ready) begin
        if (dq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL d_unexpected_output: got tag %0h, required no output", d_out_tag);
        end else begin
          e = dq.pop_front();
          chk("d_cnt", 128'(d_out_cnt), 128'(e.cnt));
          chk("d_zero", 128'(d_out_zero), 128'(e.z));
          chk("d_norm", 128'(d_out_norm), e.norm);
          chk("d_tag", 128'(d_out_tag), 128'(e.tag));
        end
        d_recv++;
        d_out_prev = d_out_last;
        d_out_last = cyc;
      end
    end
  end

  task automatic push_d(input logic [DW-1:0] data, input bit m, input logic [7:0] tag);
    exp_t e;
    ref_model(128'(data), m, DW, e.cnt, e.z, e.norm);
    e.tag = tag;
    dq.push_back(e);
  endtask

  task automatic send1(input logic [DW-1:0] data, input bit m, input logic [7:0] tag,
                       input int ecnt, input bit ez, input logic [DW-1:0] enorm);
    exp_t e;
    @(posedge clk);
    #1;
    d_in_valid = 1'b1;
    d_in_data  = data;
    d_in_mode  = m;
    d_in_tag   = tag;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (d_in_ready) begin
        e.norm = 128'(enorm);
        e.cnt  = ecnt;
        e.z    = ez;
        e.tag  = tag;
        dq.push_back(e);
        return;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_errors++;
    $display("FAIL send_timeout: in_ready stayed 0 for 20 cycles, required 1");
  endtask

  task automatic send_m(input logic [DW-1:0] data, input bit m, input logic [7:0] tag);
    int c;
    bit z;
    logic [127:0] n;
    ref_model(128'(data), m, DW, c, z, n);
    send1(data, m, tag, c, z, DW'(n));
  endtask

  task automatic idle();
    @(posedge clk);
    #1 d_in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 30 && dq.size() != 0; t++) @(negedge clk);
    chk("drain_empty", 128'(dq.size()), 128'(0));
  endtask

  task automatic bp_set(input int idx);
    if (idx <= 4) begin
      d_in_valid = 1'b1;
      d_in_data  = DW'(idx) << (idx * 7);
      d_in_mode  = idx[0];
      d_in_tag   = 8'(idx);
    end else begin
      d_in_valid = 1'b0;
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_r
    localparam int W  = (k == 0) ? 49 : ((k == 1) ? 24 : 106);
    localparam int CW = $clog2(W + 1);
    logic          in_valid, in_ready, in_mode, out_valid, out_ready, out_zero;
    logic [W-1:0]  in_data, out_norm;
    logic [7:0]    in_tag, out_tag;
    logic [CW-1:0] out_cnt;
    exp_t q[$];
    int sent = 0;
    int recv = 0;
    bit done = 1'b0;

    lzc_norm_pipe #(.WIDTH(W), .TAG_W(8)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt),
      .out_zero(out_zero), .out_norm(out_norm), .out_tag(out_tag)
    );

    initial begin
      exp_t e;
      int cyc_n;
      in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
      wait (start_rand);
      cyc_n = 0;
      while (sent < N_RAND && cyc_n < 40000) begin
        @(posedge clk);
        #1;
        in_valid  = ($urandom_range(0, 3) != 0);
        in_mode   = 1'($urandom_range(0, 1));
        in_data   = W'(rnd_op(W));
        in_tag    = 8'($urandom());
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (in_valid && in_ready) begin
          ref_model(128'(in_data), in_mode, W, e.cnt, e.z, e.norm);
          e.tag = in_tag;
          q.push_back(e);
          sent++;
        end
        cyc_n++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      while (recv < sent && cyc_n < 40000) begin
        @(negedge clk);
        cyc_n++;
      end
      chk($sformatf("w%0d_sent", W), 128'(sent), 128'(N_RAND));
      chk($sformatf("w%0d_delivered", W), 128'(recv), 128'(sent));
      done = 1'b1;
    end

    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL w%0d_unexpected: got tag %0h, required no output", W, out_tag);
          end else begin
            e = q.pop_front();
            chk($sformatf("w%0d_cnt", W), 128'(out_cnt), 128'(e.cnt));
            chk($sformatf("w%0d_zero", W), 128'(out_zero), 128'(e.z));
            chk($sformatf("w%0d_norm", W), 128'(out_norm), e.norm);
            chk($sformatf("w%0d_tag", W), 128'(out_tag), 128'(e.tag));
          end
          recv++;
        end
      end
    end
  end

  initial begin
    int c0;
    int idx;
    int r0;
    bit all_done;
    d_in_valid = 1'b0; d_in_data = '0; d_in_mode = 1'b0; d_in_tag = '0; d_out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_low", 128'(d_in_ready), 128'(0));
    chk("rst_out_valid", 128'(d_out_valid), 128'(0));
    chk("rst_out_cnt", 128'(d_out_cnt), 128'(0));
    chk("rst_out_norm", 128'(d_out_norm), 128'(0));
    chk("rst_out_tag", 128'(d_out_tag), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(d_in_ready), 128'(1));

    send1(49'h1_0000_0000_0000, 1'b0, 8'h11, 0, 1'b0, 49'h1_0000_0000_0000);
    c0 = cyc;
    idle();
    @(negedge clk);
    chk("t1_cycle1_valid", 128'(d_out_valid), 128'(0));
    @(negedge clk);
    chk("t1_cycle2_valid", 128'(d_out_valid), 128'(1));
    chk("t1_latency", 128'(cyc - c0), 128'(2));
    drain();

    send1(49'h1, 1'b0, 8'h22, 48, 1'b0, 49'h1_0000_0000_0000);
    send1(49'h0, 1'b0, 8'h23, 49, 1'b1, 49'h0);
    idle();
    drain();

    send1(49'h100, 1'b1, 8'h31, 8, 1'b0, 49'h1);
    send1(49'h0_0000_0000_00FF, 1'b0, 8'h32, 41, 1'b0, 49'h1_FE00_0000_0000);
    idle();
    drain();
    chk("t3_consecutive", 128'(d_out_last - d_out_prev), 128'(1));

    @(posedge clk);
    #1;
    d_out_ready = 1'b0;
    r0 = d_recv;
    idx = 1;
    bp_set(idx);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (d_in_valid && d_in_ready) begin
        push_d(d_in_data, d_in_mode, d_in_tag);
        idx++;
      end
      @(posedge clk);
      #1;
      bp_set(idx);
    end
    @(negedge clk);
    chk("bp_accepted", 128'(idx - 1), 128'(2));
    chk("bp_in_ready_low", 128'(d_in_ready), 128'(0));
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("bp_hold_valid", 128'(d_out_valid), 128'(1));
      chk("bp_hold_tag", 128'(d_out_tag), 128'(dq[0].tag));
      chk("bp_hold_norm", 128'(d_out_norm), dq[0].norm);
      chk("bp_hold_cnt", 128'(d_out_cnt), 128'(dq[0].cnt));
    end
    @(posedge clk);
    #1 d_out_ready = 1'b1;
    for (int t = 0; t < 20 && idx <= 4; t++) begin
      @(negedge clk);
      if (d_in_valid && d_in_ready) begin
        push_d(d_in_data, d_in_mode, d_in_tag);
        idx++;
      end
      @(posedge clk);
      #1;
      bp_set(idx);
    end
    drain();
    chk("bp_delivered", 128'(d_recv - r0), 128'(4));

    @(posedge clk);
    #1 d_out_ready = 1'b0;
    send_m(49'h3 << 20, 1'b0, 8'h51);
    send_m(49'h5 << 30, 1'b1, 8'h52);
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready_low", 128'(d_in_ready), 128'(0));
    dq.delete();
    r0 = d_recv;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 128'(d_out_valid), 128'(0));
    chk("mid_rst_out_cnt", 128'(d_out_cnt), 128'(0));
    chk("mid_rst_out_zero", 128'(d_out_zero), 128'(0));
    chk("mid_rst_out_norm", 128'(d_out_norm), 128'(0));
    chk("mid_rst_out_tag", 128'(d_out_tag), 128'(0));
    chk("mid_rst_in_ready", 128'(d_in_ready), 128'(1));
    @(posedge clk);
    #1 d_out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_stale", 128'(d_recv - r0), 128'(0));

    start_rand = 1'b1;
    all_done = 1'b0;
    for (int t = 0; t < 60000; t++) begin
      all_done = g_r[0].done && g_r[1].done && g_r[2].done;
      if (all_done) break;
      @(posedge clk);
    end
    chk("rand_done", 128'(all_done), 128'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lzc_norm_pipe.md
Name: lzc_norm_pipe

Overview:
Parametrised, pipelined zero counter and normaliser for the FPU datapath. It replaces fixed-width combinational leading-zero counters in the add, FMA and convert units. Each accepted operand goes through a 2-stage valid/ready pipeline. The block returns a leading- or trailing-zero count, an all-zero flag, and the operand shifted by that count. A sideband tag travels with each operand.

Parameters:
WIDTH, 49, operand width in bits (legal range 2..128)
CNT_W, $clog2(WIDTH+1), count width (derived; holds the value WIDTH)
TAG_W, 8, sideband tag width (legal range 1..32)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand valid
in_ready  output  1  block can accept an operand this cycle
in_data  input  WIDTH  operand
in_mode  input  1  0 = count leading zeros (from MSB); 1 = count trailing zeros (from LSB)
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_cnt  output  CNT_W  zero count
out_zero  output  1  operand was all zeros
out_norm  output  WIDTH  normalised operand
out_tag  output  TAG_W  tag of this result

Behaviour:
- Transfers: input transfer happens when in_valid && in_ready; output transfer happens when out_valid && out_ready.
- Stage 1 (S1) registers the following on an input transfer:
  - operand, mode and tag;
  - per-8-bit-group nonzero flags and per-group local counts. The MSB group is padded with zeros when WIDTH % 8 != 0.
- Stage 2 (S2) is the output register. It holds cnt, zero, norm and tag.
  - S2 computes cnt as a priority select over the group flags plus the local count.
  - Mode 0: norm = operand << cnt.
  - Mode 1: norm = operand >> cnt.
  - Shifts are logical and zero-filled.
- Latency: 2 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 operand per cycle.
- All-zero operand: cnt = WIDTH, zero = 1, norm = 0, in both modes.
- Any nonzero operand: zero = 0 and cnt <= WIDTH-1.
  - Mode 0: norm[WIDTH-1] = 1.
  - Mode 1: norm[0] = 1.
- Pipeline control, with v1/v2 as the S1/S2 valid bits:
  - S2 loads from S1 when v1 && (!v2 || out_ready).
  - S1 loads when in_ready, where in_ready = !v1 || !v2 || out_ready.
  - There is no combinational path from in_valid to out_valid. The only combinational path is out_ready -> in_ready.
  - Data at the outputs stays stable while out_valid && !out_ready.
  - Results leave in order; none are dropped or duplicated.
- Simultaneous output and input transfer when full: S2 takes S1's contents and S1 takes the new operand in the same cycle, with no bubble.
- Reset (including mid-operation):
  - v1 and v2 clear, so out_valid = 0 and all in-flight operands are discarded.
  - out_cnt, out_zero, out_norm and out_tag reset to 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - in_ready is 0 while rst is high.
- Idle: out_* data registers hold their last value while out_valid = 0.
- in_mode is sampled per operand, so modes may alternate back to back.

Test Plan:
- WIDTH=49, mode 0, in_data=49'h1_0000_0000_0000 (bit 48 set), tag 8'h11 -> two cycles later: out_cnt=0, out_zero=0, out_norm=49'h1_0000_0000_0000, out_tag=8'h11.
- Mode 0, in_data=49'h1 -> out_cnt=48, out_norm=49'h1_0000_0000_0000. Then in_data=49'h0 -> out_cnt=49, out_zero=1, out_norm=0.
- Back-to-back, alternating modes: {mode 1, 49'h100} then {mode 0, 49'h0_0000_0000_00FF} -> first result out_cnt=8, out_norm=49'h1; second result out_cnt=41, out_norm=49'h1_FE00_0000_0000. Results appear on consecutive cycles.
- Backpressure: hold out_ready=0 and offer 4 operands with tags 1..4.
  - Exactly 2 are accepted, and in_ready drops to 0.
  - Raising out_ready delivers tags 1,2,3,4 in order with no loss.
  - The output held stable during the stall.
- Reset mid-flight: with 2 operands in flight, pulse rst for 1 cycle -> out_valid=0 and all out_* = 0 the next cycle, in_ready=1 afterwards, and no stale result appears.
- Randomised: 10k operands with random valid/ready, both modes, WIDTH in {49, 24, 106} -> every result matches a reference zero-count model exactly.
